// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU: single-cycle add/inc/sub/dec, iterative shift-add half-width multiply
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             carry,
    output logic             err
);
    localparam int HW = WIDTH / 2;
    localparam int CW = $clog2(HW + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [HW-1:0]    mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;
    logic             rsv;
    logic             accept;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign rsv       = f[2] && (f[1:0] != 2'b00);

    // Top bit of sum is carry-out for add/inc and borrow for sub/dec.
    always_comb begin
        sum = '0;
        case (f)
            3'b000:  sum = {1'b0, a} + {1'b0, b};
            3'b001:  sum = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
            3'b010:  sum = {1'b0, a} - {1'b0, b};
            3'b011:  sum = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
            default: sum = '0;
        endcase
    end

    // Multiplicand is pre-shifted each step, equivalent to multiplicand << cnt.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            r      <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (f == 3'b100) begin
                            mcand  <= {{(WIDTH-HW){1'b0}}, a[HW-1:0]};
                            mplier <= b[HW-1:0];
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= MUL;
                        end else begin
                            r     <= sum[WIDTH-1:0];
                            zero  <= (sum[WIDTH-1:0] == '0);
                            carry <= sum[WIDTH];
                            err   <= rsv;
                            state <= DONE;
                        end
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(HW - 1)) begin
                        r     <= acc_next;
                        zero  <= (acc_next == '0);
                        carry <= 1'b0;
                        err   <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed table-driven bench for alu_seq (WIDTH=32 and WIDTH=8)
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  f = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] r;
    logic        zero, carry, err;

    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, r8;
    logic [2:0]  f8 = '0;
    logic        z8, c8, e8;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .zero(zero), .carry(carry), .err(err)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .f(f8), .out_valid(ov8), .out_ready(or8),
        .r(r8), .zero(z8), .carry(c8), .err(e8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        e;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic [2:0] xf,
                          output logic [31:0] rr, output logic rz, output logic rc,
                          output logic re, output int lat, output int busy_rdy);
        int guard;
        @(negedge clk);
        a = xa; b = xb; f = xf; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; f = 3'b001;
        lat = 0;
        busy_rdy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) busy_rdy++;
        end while (!out_valid && lat < 100);
        rr = r; rz = zero; rc = carry; re = err;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rr;
        logic        rz, rc, re;
        int          lat, busy, seen;

        tbl[0]  = '{32'd5,         32'd7,         3'b000, 32'd12,        1'b0, 1'b0, 1'b0, 1};
        tbl[1]  = '{32'hFFFF_FFFF, 32'd0,         3'b001, 32'd0,         1'b1, 1'b1, 1'b0, 1};
        tbl[2]  = '{32'd0,         32'd0,         3'b011, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1};
        tbl[3]  = '{32'd3,         32'd5,         3'b010, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1};
        tbl[4]  = '{32'd5,         32'd3,         3'b010, 32'd2,         1'b0, 1'b0, 1'b0, 1};
        tbl[5]  = '{32'h1234_FFFF, 32'hABCD_FFFF, 3'b100, 32'hFFFE_0001, 1'b0, 1'b0, 1'b0, 17};
        tbl[6]  = '{32'd9,         32'd4,         3'b110, 32'd0,         1'b1, 1'b0, 1'b1, 1};
        tbl[7]  = '{32'd1,         32'd2,         3'b000, 32'd3,         1'b0, 1'b0, 1'b0, 1};
        tbl[8]  = '{32'hFFFF_FFFF, 32'd1,         3'b000, 32'd0,         1'b1, 1'b1, 1'b0, 1};
        tbl[9]  = '{32'hFFFF_0003, 32'h0001_0004, 3'b100, 32'd12,        1'b0, 1'b0, 1'b0, 17};
        tbl[10] = '{32'd9,         32'd9,         3'b101, 32'd0,         1'b1, 1'b0, 1'b1, 1};
        tbl[11] = '{32'd100,       32'd1,         3'b111, 32'd0,         1'b1, 1'b0, 1'b1, 1};
        tbl[12] = '{32'd0,         32'h0000_1234, 3'b100, 32'd0,         1'b1, 1'b0, 1'b0, 17};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_r", r, 32'd0);
        chk("rst_flags", {29'd0, zero, carry, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].f, rr, rz, rc, re, lat, busy);
            chk($sformatf("v%0d_r", i), rr, tbl[i].r);
            chk($sformatf("v%0d_zce", i), {29'd0, rz, rc, re}, {29'd0, tbl[i].z, tbl[i].c, tbl[i].e});
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_busy_in_ready", i), busy, 32'd0);
        end

        // Backpressure: hold the result 10 cycles, then stream four adds back to back.
        @(negedge clk);
        a = 32'd10; b = 32'd20; f = 3'b000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'd77; b = 32'd88; f = 3'b010;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_hold", k), {out_valid, in_ready, zero, carry, err, r[26:0]},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 27'd30});
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = k * 100; b = 32'd1; f = 3'b000; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("stream%0d", k), {out_valid, r[30:0]}, {1'b1, 31'(k * 100 + 1)});
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("stream_drain", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset in the middle of a multiply.
        a = 32'd7; b = 32'd9; f = 3'b100; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_r", r, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_discarded", seen, 32'd0);
        run_op(32'd3, 32'd4, 3'b100, rr, rz, rc, re, lat, busy);
        chk("postrst_mul_r", rr, 32'd12);
        chk("postrst_mul_lat", lat, 32'd17);

        // Narrow instance: upper operand nibbles must be ignored by the multiply.
        @(negedge clk);
        a8 = 8'hAF; b8 = 8'h5F; f8 = 3'b100; iv8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov8 && lat < 50);
        chk("w8_mul_r", {24'd0, r8}, 32'h0000_00E1);
        chk("w8_mul_lat", lat, 32'd5);
        chk("w8_flags", {29'd0, z8, c8, e8}, 32'd0);
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0;
        chk("w8_consumed", {31'd0, ov8}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
